// File: rtl/coverfloat_vector_loader.sv
// Deserializes 20-word frames into coverfloat transaction fields and presents
// each completed transaction to the coverage sampler over a valid/ready handshake.
module coverfloat_vector_loader #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        op,
  output logic [31:0]        rm,
  output logic [127:0]       a,
  output logic [127:0]       b,
  output logic [127:0]       c,
  output logic [7:0]         aFmt,
  output logic [7:0]         bFmt,
  output logic [7:0]         cFmt,
  output logic [7:0]         resultFmt,
  output logic [127:0]       result,
  output logic [31:0]        exceptionBits,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   frame_err_count
);

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned WIDE_W      = 128;
  localparam int unsigned FMT_W       = 8;
  localparam int unsigned FRAME_WORDS = 20;
  localparam int unsigned IDX_W       = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  typedef enum logic [0:0] {
    ASSEMBLE = 1'b0,
    PENDING  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic [WORD_W-1:0]  asm_q [FRAME_WORDS];

  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   txn_count_q, txn_count_d;
  logic [CNT_W-1:0]   frame_err_q, frame_err_d;

  logic [WORD_W-1:0]  op_q, rm_q, exc_q;
  logic [WIDE_W-1:0]  a_q, b_q, c_q, result_q;
  logic [FMT_W-1:0]   afmt_q, bfmt_q, cfmt_q, rfmt_q;

  logic               accept_c;
  logic               load_c;
  logic               consume_c;
  logic               frame_err_c;

  assign in_ready  = (state_q == ASSEMBLE);
  assign accept_c  = in_valid && in_ready;
  assign consume_c = out_valid_q && out_ready;
  assign load_c    = (state_q == PENDING) && (!out_valid_q || out_ready);

  // Frame sequencing, handshake bookkeeping and saturating counters
  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    frame_err_c = 1'b0;
    out_valid_d = out_valid_q;
    txn_count_d = txn_count_q;
    frame_err_d = frame_err_q;

    case (state_q)
      ASSEMBLE: begin
        if (accept_c) begin
          if (widx_q == LAST_IDX) begin
            widx_d = '0;
            if (in_last) begin
              state_d = PENDING;
            end else begin
              frame_err_c = 1'b1;
            end
          end else if (in_last) begin
            widx_d      = '0;
            frame_err_c = 1'b1;
          end else begin
            widx_d = widx_q + IDX_W'(1);
          end
        end
      end
      PENDING: begin
        if (load_c) begin
          state_d = ASSEMBLE;
        end
      end
      default: begin
        state_d = ASSEMBLE;
        widx_d  = '0;
      end
    endcase

    // A reload on the consuming edge keeps out_valid asserted
    if (load_c) begin
      out_valid_d = 1'b1;
    end else if (consume_c) begin
      out_valid_d = 1'b0;
    end

    if (consume_c && (txn_count_q != {CNT_W{1'b1}})) begin
      txn_count_d = txn_count_q + CNT_W'(1);
    end
    if (frame_err_c && (frame_err_q != {CNT_W{1'b1}})) begin
      frame_err_d = frame_err_q + CNT_W'(1);
    end
  end

  // Control state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ASSEMBLE;
      widx_q      <= '0;
      out_valid_q <= 1'b0;
      txn_count_q <= '0;
      frame_err_q <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      out_valid_q <= out_valid_d;
      txn_count_q <= txn_count_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Assembly buffer, one slot per frame word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FRAME_WORDS); i++) begin
        asm_q[i] <= '0;
      end
    end else if (accept_c) begin
      asm_q[widx_q] <= in_data;
    end
  end

  // Output transaction registers; 128-bit fields arrive least-significant word first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      rm_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      afmt_q   <= '0;
      bfmt_q   <= '0;
      cfmt_q   <= '0;
      rfmt_q   <= '0;
      result_q <= '0;
      exc_q    <= '0;
    end else if (load_c) begin
      op_q     <= asm_q[0];
      rm_q     <= asm_q[1];
      a_q      <= {asm_q[5],  asm_q[4],  asm_q[3],  asm_q[2]};
      b_q      <= {asm_q[9],  asm_q[8],  asm_q[7],  asm_q[6]};
      c_q      <= {asm_q[13], asm_q[12], asm_q[11], asm_q[10]};
      afmt_q   <= asm_q[14][7:0];
      bfmt_q   <= asm_q[14][15:8];
      cfmt_q   <= asm_q[14][23:16];
      rfmt_q   <= asm_q[14][31:24];
      result_q <= {asm_q[18], asm_q[17], asm_q[16], asm_q[15]};
      exc_q    <= asm_q[19];
    end
  end

  assign out_valid       = out_valid_q;
  assign op              = op_q;
  assign rm              = rm_q;
  assign a               = a_q;
  assign b               = b_q;
  assign c               = c_q;
  assign aFmt            = afmt_q;
  assign bFmt            = bfmt_q;
  assign cFmt            = cfmt_q;
  assign resultFmt       = rfmt_q;
  assign result          = result_q;
  assign exceptionBits   = exc_q;
  assign txn_count       = txn_count_q;
  assign frame_err_count = frame_err_q;

endmodule

// File: tb/tb_coverfloat_vector_loader.sv
// Directed bench for coverfloat_vector_loader: a 16-bit-counter instance for function
// and a 4-bit-counter instance sharing the same stimulus for saturation.
module tb_coverfloat_vector_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [31:0] in_data;
  logic in_last;
  logic out_ready;

  logic in_ready, out_valid;
  logic [31:0] op, rm, exceptionBits;
  logic [127:0] a, b, c, result;
  logic [7:0] aFmt, bFmt, cFmt, resultFmt;
  logic [15:0] txn_count, frame_err_count;

  logic in_ready_s, out_valid_s;
  logic [31:0] op_s, rm_s, exc_s;
  logic [127:0] a_s, b_s, c_s, result_s;
  logic [7:0] afmt_s, bfmt_s, cfmt_s, rfmt_s;
  logic [3:0] txn_count_s, frame_err_count_s;

  int checks = 0;
  int errors = 0;

  logic [639:0] got;
  logic [639:0] cap_q[$];
  int ir_low;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  coverfloat_vector_loader #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .rm(rm), .a(a), .b(b), .c(c), .aFmt(aFmt), .bFmt(bFmt), .cFmt(cFmt),
    .resultFmt(resultFmt), .result(result), .exceptionBits(exceptionBits),
    .txn_count(txn_count), .frame_err_count(frame_err_count)
  );

  coverfloat_vector_loader #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
    .op(op_s), .rm(rm_s), .a(a_s), .b(b_s), .c(c_s), .aFmt(afmt_s), .bFmt(bfmt_s),
    .cFmt(cfmt_s), .resultFmt(rfmt_s), .result(result_s), .exceptionBits(exc_s),
    .txn_count(txn_count_s), .frame_err_count(frame_err_count_s)
  );

  assign got = {op, rm, a, b, c, aFmt, bFmt, cFmt, resultFmt, result, exceptionBits};

  // Transactions handed to the sampler and in_ready-low cycles, seen at the edge
  always @(posedge clk) begin
    if (mon_en) begin
      if (!in_ready) ir_low++;
      if (out_valid && out_ready) cap_q.push_back(got);
    end
  end

  // Frame whose word k is base+k, packed in the same order as 'got'
  function automatic logic [639:0] exp_txn(input logic [31:0] base);
    logic [31:0] w [20];
    for (int k = 0; k < 20; k++) w[k] = base + 32'(k);
    return {w[0], w[1], w[5], w[4], w[3], w[2], w[9], w[8], w[7], w[6],
            w[13], w[12], w[11], w[10],
            w[14][7:0], w[14][15:8], w[14][23:16], w[14][31:24],
            w[18], w[17], w[16], w[15], w[19]};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    int stalls = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && stalls < 100) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 100) begin
      checks++; errors++;
      $display("FAIL send_timeout word %h never accepted", d);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base);
    for (int k = 0; k < 20; k++) send_word(base + 32'(k), k == 19);
  endtask

  task automatic start_mon();
    cap_q.delete(); ir_low = 0; mon_en = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (got !== 640'd0) begin errors++; $display("FAIL rst_fields got %h exp 0", got); end
    checks++; if (txn_count !== 16'd0) begin errors++; $display("FAIL rst_txn got %0d exp 0", txn_count); end
    checks++; if (frame_err_count !== 16'd0) begin errors++; $display("FAIL rst_err got %0d exp 0", frame_err_count); end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    send_frame(32'h100);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_pending_ready got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (op !== 32'h100) begin errors++; $display("FAIL single_op got %h exp 100", op); end
    checks++; if (a !== 128'h00000105_00000104_00000103_00000102) begin errors++; $display("FAIL single_a got %h exp 00000105000001040000010300000102", a); end
    checks++; if (aFmt !== 8'h0E) begin errors++; $display("FAIL single_afmt got %h exp 0e", aFmt); end
    checks++; if (bFmt !== 8'h01 || resultFmt !== 8'h00) begin errors++; $display("FAIL single_fmts got b=%h r=%h exp b=01 r=00", bFmt, resultFmt); end
    checks++; if (exceptionBits !== 32'h113) begin errors++; $display("FAIL single_exc got %h exp 113", exceptionBits); end
    checks++; if (got !== exp_txn(32'h100)) begin errors++; $display("FAIL single_txn got %h exp %h", got, exp_txn(32'h100)); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_consumed got %b exp 0", out_valid); end
    checks++; if (txn_count !== 16'd1) begin errors++; $display("FAIL single_txn_count got %0d exp 1", txn_count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bases [3];
    bases[0] = 32'h200; bases[1] = 32'h300; bases[2] = 32'h400;
    do_reset();
    out_ready = 1'b1;
    start_mon();
    for (int f = 0; f < 3; f++) send_frame(bases[f]);
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    checks++; if (cap_q.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", cap_q.size()); end
    for (int f = 0; f < 3 && f < cap_q.size(); f++) begin
      checks++; if (cap_q[f] !== exp_txn(bases[f])) begin errors++; $display("FAIL b2b_txn%0d got %h exp %h", f, cap_q[f], exp_txn(bases[f])); end
    end
    checks++; if (ir_low != 3) begin errors++; $display("FAIL b2b_ready_low got %0d exp 3", ir_low); end
    checks++; if (txn_count !== 16'd3) begin errors++; $display("FAIL b2b_txn_count got %0d exp 3", txn_count); end
    checks++; if (frame_err_count !== 16'd0) begin errors++; $display("FAIL b2b_err got %0d exp 0", frame_err_count); end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    send_frame(32'h500);
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_first_valid got %b exp 1", out_valid); end
    for (int k = 0; k < 20; k++) begin
      send_word(32'h600 + 32'(k), k == 19);
      if (k == 10) begin
        checks++; if (got !== exp_txn(32'h500)) begin errors++; $display("FAIL stall_hold_mid got %h exp %h", got, exp_txn(32'h500)); end
      end
    end
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || got !== exp_txn(32'h500)) begin errors++; $display("FAIL stall_hold got v=%b %h exp v=1 %h", out_valid, got, exp_txn(32'h500)); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
    checks++; if (txn_count !== 16'd0) begin errors++; $display("FAIL stall_txn0 got %0d exp 0", txn_count); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || got !== exp_txn(32'h600)) begin errors++; $display("FAIL stall_second got v=%b %h exp v=1 %h", out_valid, got, exp_txn(32'h600)); end
    checks++; if (txn_count !== 16'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_after_reload got txn=%0d rdy=%b exp txn=1 rdy=1", txn_count, in_ready); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || txn_count !== 16'd2) begin errors++; $display("FAIL stall_drain got v=%b txn=%0d exp v=0 txn=2", out_valid, txn_count); end
  endtask

  task automatic test_frame_err();
    do_reset();
    out_ready = 1'b1;
    start_mon();
    for (int k = 0; k < 8; k++) send_word(32'h700 + 32'(k), k == 7);
    checks++; if (frame_err_count !== 16'd1) begin errors++; $display("FAIL err_short got %0d exp 1", frame_err_count); end
    send_frame(32'h800);
    for (int k = 0; k < 20; k++) send_word(32'h900 + 32'(k), 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (frame_err_count !== 16'd2) begin errors++; $display("FAIL err_nolast got %0d exp 2", frame_err_count); end
    checks++; if (txn_count !== 16'd1) begin errors++; $display("FAIL err_txn got %0d exp 1", txn_count); end
    send_frame(32'hA00);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    checks++; if (cap_q.size() != 2) begin errors++; $display("FAIL err_deliveries got %0d exp 2", cap_q.size()); end
    if (cap_q.size() >= 2) begin
      checks++; if (cap_q[0] !== exp_txn(32'h800)) begin errors++; $display("FAIL err_good_frame got %h exp %h", cap_q[0], exp_txn(32'h800)); end
      checks++; if (cap_q[1] !== exp_txn(32'hA00)) begin errors++; $display("FAIL err_resync_frame got %h exp %h", cap_q[1], exp_txn(32'hA00)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    send_frame(32'hB00);
    for (int k = 0; k < 3; k++) send_word(32'hBE0 + 32'(k), k == 2);
    out_ready = 1'b0;
    send_frame(32'hB80);
    repeat (2) @(negedge clk);
    checks++; if (txn_count !== 16'd1 || frame_err_count !== 16'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got txn=%0d err=%0d v=%b exp txn=1 err=1 v=1", txn_count, frame_err_count, out_valid); end
    for (int k = 0; k < 12; k++) send_word(32'hC00 + 32'(k), 1'b0);
    in_valid = 1'b1; in_data = 32'hC0C; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || got !== 640'd0) begin errors++; $display("FAIL rmid_outputs got v=%b %h exp v=0 zero", out_valid, got); end
    checks++; if (txn_count !== 16'd0 || frame_err_count !== 16'd0) begin errors++; $display("FAIL rmid_counters got txn=%0d err=%0d exp 0 0", txn_count, frame_err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
    out_ready = 1'b1;
    send_frame(32'hD00);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || got !== exp_txn(32'hD00)) begin errors++; $display("FAIL rmid_next got v=%b %h exp v=1 %h", out_valid, got, exp_txn(32'hD00)); end
    @(negedge clk);
    checks++; if (txn_count !== 16'd1 || frame_err_count !== 16'd0) begin errors++; $display("FAIL rmid_next_count got txn=%0d err=%0d exp 1 0", txn_count, frame_err_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_frame(32'h1000 * 32'(i + 1));
    repeat (4) @(negedge clk);
    checks++; if (txn_count !== 16'd17) begin errors++; $display("FAIL sat_wide got %0d exp 17", txn_count); end
    checks++; if (txn_count_s !== 4'hF) begin errors++; $display("FAIL sat_narrow got %h exp f", txn_count_s); end
    checks++; if (out_valid_s !== 1'b0 || frame_err_count_s !== 4'h0) begin errors++; $display("FAIL sat_narrow_state got v=%b err=%h exp v=0 err=0", out_valid_s, frame_err_count_s); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_frame_err();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
